panda_lsu: RTL and testbench

//  Parametrised multi-cycle load/store unit for the Panda core; replaces the combinational LSU path of the single-cycle datapath.

---
 rtl/panda_lsu.sv | 235 +++++++++++++++++++++++
 tb/tb_panda_lsu.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : panda_lsu
//  Purpose  : Multi-cycle load/store unit. Takes one core request at a time,
//             runs an OBI-style req/gnt/rvalid bus transaction, aligns store
//             data and byte enables to the bus lanes, and sign/zero-extends
//             the load result. With MISALIGN_EN=1 an access that crosses a
//             bus-word boundary is split into two aligned beats; otherwise a
//             misaligned access completes immediately with an error.
//  Ports    : clk_i, rst_ni (async, active-low)
//             core side : req_i, we_i, width_i, unsigned_i, addr_i, wdata_i,
//                         busy_o, valid_o, rdata_o, err_o
//             bus side  : data_req_o, data_gnt_i, data_addr_o, data_we_o,
//                         data_be_o, data_wdata_o, data_rvalid_i,
//                         data_rdata_i, data_err_i
//  Revision : 1.0 - initial release
// ============================================================================
module panda_lsu #(
  parameter int XLEN        = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        width_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              err_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic [XLEN-1:0]   data_addr_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,
  input  logic              data_err_i
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        width_q, width_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [OW-1:0]     off_q;
  logic              split_q;
  logic [2*NB-1:0]   size_mask;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic [XLEN-1:0]   base_addr;
  logic [XLEN-1:0]   rd_lo, rd_hi, rd_raw;

  // Access crosses a bus-word boundary.
  function automatic logic is_split(input logic [OW-1:0] off, input logic [1:0] w);
    return (int'(off) + (1 << w)) > NB;
  endfunction

  // Address not a multiple of the access size.
  function automatic logic is_misal(input logic [OW-1:0] off, input logic [1:0] w);
    return (int'(off) & ((1 << w) - 1)) != 0;
  endfunction

  function automatic logic is_illegal(input logic [1:0] w);
    return (XLEN == 32) && (w == 2'b11);
  endfunction

  // Keep the low 8<<w bits of raw and extend the rest from its top bit.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [1:0] w,
                                             input logic uns);
    logic [XLEN-1:0] r;
    int              nbits;
    logic            s;
    nbits = 8 << w;
    if (nbits > XLEN) nbits = XLEN;
    s = uns ? 1'b0 : raw[nbits-1];
    for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? raw[i] : s;
    return r;
  endfunction

  assign off_q     = addr_q[OW-1:0];
  assign split_q   = is_split(off_q, width_q);
  assign base_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};

  always_comb begin
    size_mask = '0;
    case (width_q)
      2'b00:   size_mask = (2*NB)'(8'h01);
      2'b01:   size_mask = (2*NB)'(8'h03);
      2'b10:   size_mask = (2*NB)'(8'h0F);
      default: size_mask = (2*NB)'(8'hFF);
    endcase
  end

  // Enables and data laid out over two bus words; the upper half is beat 2.
  assign be_wide    = size_mask << off_q;
  assign wdata_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};

  // Load assembly: in WAIT2 beat 1 comes from the buffer, beat 2 from the bus.
  assign rd_lo  = (state_q == S_WAIT2) ? buf_q : data_rdata_i;
  assign rd_hi  = (state_q == S_WAIT2) ? data_rdata_i : '0;
  assign rd_raw = XLEN'({rd_hi, rd_lo} >> {off_q, 3'b000});

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    width_d      = width_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    buf_d        = buf_q;
    rdata_d      = rdata_q;
    data_req_o   = 1'b0;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          width_d = width_i;
          uns_d   = unsigned_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          buf_d   = '0;
          if (is_illegal(width_i) ||
              ((MISALIGN_EN == 0) && is_misal(addr_i[OW-1:0], width_i))) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ1;
          end
        end
      end
      S_REQ1: begin
        data_req_o   = 1'b1;
        data_addr_o  = base_addr;
        data_we_o    = we_q;
        data_be_o    = be_wide[NB-1:0];
        data_wdata_o = wdata_wide[XLEN-1:0];
        if (data_gnt_i) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (data_rvalid_i) begin
          buf_d = data_rdata_i;
          if (data_err_i) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end else if (split_q) begin
            state_d = S_REQ2;
          end else begin
            rdata_d = we_q ? '0 : extend(rd_raw, width_q, uns_q);
            state_d = S_DONE;
          end
        end
      end
      S_REQ2: begin
        data_req_o   = 1'b1;
        data_addr_o  = base_addr + XLEN'(NB);
        data_we_o    = we_q;
        data_be_o    = be_wide[2*NB-1:NB];
        data_wdata_o = wdata_wide[2*XLEN-1:XLEN];
        if (data_gnt_i) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (data_rvalid_i) begin
          err_d   = data_err_i;
          rdata_d = (we_q || data_err_i) ? '0 : extend(rd_raw, width_q, uns_q);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      width_q <= width_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign err_o   = valid_o & err_q;
  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_panda_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_panda_lsu
//  Purpose  : Self-checking bench for panda_lsu. Two instances share the core
//             inputs: u_dut (MISALIGN_EN=1) on a memory-backed bus with
//             controllable grant/error, u_dut0 (MISALIGN_EN=0) on an
//             always-granting bus. Expectations come from a byte-addressed
//             memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_panda_lsu;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  width = 2'b00;
  logic [31:0] addr = '0, wdata = '0;

  logic        busy, valid, err, dreq, dgnt, dwe, drvalid, derr;
  logic [31:0] rdata, daddr, dwdata, drdata;
  logic [3:0]  dbe;
  logic        busy0, valid0, err0, dreq0, dwe0, rv0;
  logic [31:0] rdata0, daddr0, dwdata0;
  logic [3:0]  dbe0;

  logic        gnt_en = 1'b1, err_inj = 1'b0, spur = 1'b0;
  logic        rv_q, er_q;
  logic [31:0] rd_q;

  int n_cmp = 0, n_fail = 0, n_req0 = 0;

  logic [31:0] mem [256];
  logic [7:0]  sh  [1024];
  logic [31:0] b_addr[$], b_wd[$];
  logic [3:0]  b_be[$];
  logic        b_we[$];

  assign dgnt    = dreq & gnt_en;
  assign drvalid = rv_q | spur;
  assign drdata  = rd_q;
  assign derr    = er_q & rv_q;

  panda_lsu #(.XLEN(32), .MISALIGN_EN(1)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .we_i(we), .width_i(width),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .busy_o(busy),
    .valid_o(valid), .rdata_o(rdata), .err_o(err), .data_req_o(dreq),
    .data_gnt_i(dgnt), .data_addr_o(daddr), .data_we_o(dwe), .data_be_o(dbe),
    .data_wdata_o(dwdata), .data_rvalid_i(drvalid), .data_rdata_i(drdata),
    .data_err_i(derr));

  panda_lsu #(.XLEN(32), .MISALIGN_EN(0)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .we_i(we), .width_i(width),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .busy_o(busy0),
    .valid_o(valid0), .rdata_o(rdata0), .err_o(err0), .data_req_o(dreq0),
    .data_gnt_i(1'b1), .data_addr_o(daddr0), .data_we_o(dwe0), .data_be_o(dbe0),
    .data_wdata_o(dwdata0), .data_rvalid_i(rv0), .data_rdata_i(32'h0),
    .data_err_i(1'b0));

  // Memory-backed bus slave: response one cycle after grant.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rv_q <= 1'b0; rd_q <= '0; er_q <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      er_q <= 1'b0;
      if (dreq && dgnt) begin
        n_cmp++;
        if (rv_q) begin
          n_fail++;
          $display("FAIL outstanding: grant with response pending, got 1 expected 0");
        end
        rv_q <= 1'b1;
        rd_q <= mem[daddr[9:2]];
        er_q <= err_inj && (b_addr.size() == 0);
        if (dwe)
          for (int k = 0; k < 4; k++)
            if (dbe[k]) mem[daddr[9:2]][8*k +: 8] <= dwdata[8*k +: 8];
        b_addr.push_back(daddr); b_be.push_back(dbe);
        b_wd.push_back(dwdata);  b_we.push_back(dwe);
      end
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rv0 <= 1'b0;
    else begin
      rv0 <= dreq0;
      if (dreq0) n_req0++;
    end
  end

  task automatic set_word(input int a, input logic [31:0] v);
    mem[a/4] = v;
    for (int k = 0; k < 4; k++) sh[(a & ~3) + k] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input logic u);
    int size;
    logic [31:0] v;
    size = 1 << w;
    v = '0;
    for (int k = 0; k < size; k++) v[8*k +: 8] = sh[(a + k) & 32'h3FF];
    if (!u && v[8*size-1])
      for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_access(input logic iwe, input logic [1:0] iw, input logic iu,
                           input logic [31:0] ia, input logic [31:0] iwd,
                           input int stall, input logic einj,
                           output int lat, output logic [31:0] rd, output logic e,
                           output int lat0, output logic e0);
    int guard;
    logic [31:0] a1;
    logic [3:0]  be1;
    guard = 0;
    while ((busy || busy0) && guard < 50) begin @(negedge clk_i); guard++; end
    if (busy || busy0) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_wait: busy got 1 expected 0");
    end
    b_addr.delete(); b_be.delete(); b_wd.delete(); b_we.delete();
    err_inj = einj;
    gnt_en  = (stall == 0);
    req = 1'b1; we = iwe; width = iw; uns = iu; addr = ia; wdata = iwd;
    lat = 0; lat0 = 0; e = 1'b0; e0 = 1'b0; rd = '0; a1 = '0; be1 = '0;
    @(posedge clk_i);
    do begin
      @(negedge clk_i);
      lat++;
      if (lat == 1) begin
        req = 1'b0; we = ~iwe; addr = $urandom; wdata = $urandom; width = 2'($urandom);
        a1 = daddr; be1 = dbe;
      end
      gnt_en = (lat > stall);
      if (stall > 0 && lat > 1 && lat <= stall + 1) begin
        n_cmp++;
        if ({dreq, daddr, dbe} !== {1'b1, a1, be1}) begin
          n_fail++;
          $display("FAIL stall_stable: got req=%b addr=%h be=%b expected req=1 addr=%h be=%b",
                   dreq, daddr, dbe, a1, be1);
        end
      end
      if (valid0 && lat0 == 0) begin lat0 = lat; e0 = err0; end
      if (valid) begin rd = rdata; e = err; end
    end while (!valid && lat < 60);
    if (!valid) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: valid_o got 0 expected 1 within 60 cycles");
    end
    err_inj = 1'b0;
    gnt_en  = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({busy, valid, err, dreq, dwe, dbe, daddr, dwdata, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b req=%b rdata=%h expected all 0",
               busy, valid, dreq, rdata);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_lw_basic();
    int lat, lat0; logic [31:0] rd; logic e, e0;
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1'b0, lat, rd, e, lat0, e0);
    n_cmp++;
    if (lat !== 3 || rd !== 32'hABCDEF78 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_basic: got lat=%0d rdata=%h err=%b expected lat=3 rdata=abcdef78 err=0", lat, rd, e);
    end
    n_cmp++;
    if (b_addr.size() != 1 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1111) begin
      n_fail++;
      $display("FAIL lw_beat: got beats=%0d expected 1 beat addr=100 be=1111", b_addr.size());
    end
    @(negedge clk_i);
    n_cmp++;
    if (valid !== 1'b0 || rdata !== 32'hABCDEF78) begin
      n_fail++;
      $display("FAIL valid_pulse: got valid=%b rdata=%h expected valid=0 rdata=abcdef78", valid, rdata);
    end
  endtask

  task automatic test_load_ext();
    int lat, lat0; logic [31:0] rd; logic e, e0;
    do_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, 1'b0, lat, rd, e, lat0, e0);
    n_cmp++;
    if (rd !== 32'h00000078) begin n_fail++; $display("FAIL lb_100: got %h expected 00000078", rd); end
    do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 1'b0, lat, rd, e, lat0, e0);
    n_cmp++;
    if (rd !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL lb_103: got %h expected ffffffab", rd); end
    do_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 1'b0, lat, rd, e, lat0, e0);
    n_cmp++;
    if (rd !== 32'h0000ABCD) begin n_fail++; $display("FAIL lhu_102: got %h expected 0000abcd", rd); end
    do_access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 1'b0, lat, rd, e, lat0, e0);
    n_cmp++;
    if (lat !== 1 || e !== 1'b1 || b_addr.size() != 0) begin
      n_fail++;
      $display("FAIL illegal_width: got lat=%0d err=%b beats=%0d expected lat=1 err=1 beats=0", lat, e, b_addr.size());
    end
  endtask

  task automatic test_misaligned();
    int lat, lat0, r0; logic [31:0] rd; logic e, e0;
    r0 = n_req0;
    do_access(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 0, 1'b0, lat, rd, e, lat0, e0);
    n_cmp++;
    if (lat !== 5 || rd !== 32'h223344AB || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_split: got lat=%0d rdata=%h err=%b expected lat=5 rdata=223344ab err=0", lat, rd, e);
    end
    n_cmp++;
    if (b_addr.size() != 2 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1000 ||
        b_addr[1] !== 32'h104 || b_be[1] !== 4'b0111) begin
      n_fail++;
      $display("FAIL lw_split_beats: got beats=%0d expected 100/1000 then 104/0111", b_addr.size());
    end
    n_cmp++;
    if (lat0 !== 1 || e0 !== 1'b1 || n_req0 != r0) begin
      n_fail++;
      $display("FAIL misal_err: got lat=%0d err=%b bus_reqs=%0d expected lat=1 err=1 bus_reqs=0", lat0, e0, n_req0 - r0);
    end
  endtask

  task automatic test_store_split();
    int lat, lat0; logic [31:0] rd; logic e, e0;
    do_access(1'b1, 2'b01, 1'b0, 32'h107, 32'h0000BEEF, 0, 1'b0, lat, rd, e, lat0, e0);
    sh[32'h107] = 8'hEF; sh[32'h108] = 8'hBE;
    n_cmp++;
    if (b_addr.size() != 2 || b_addr[0] !== 32'h104 || b_be[0] !== 4'b1000 || b_wd[0] !== 32'hEF000000 ||
        b_addr[1] !== 32'h108 || b_be[1] !== 4'b0001 || b_wd[1] !== 32'h000000BE || b_we[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_split: got beats=%0d expected 104/1000/ef000000 then 108/0001/000000be", b_addr.size());
    end
    n_cmp++;
    if (rd !== 32'h0 || e !== 1'b0 || lat !== 5) begin
      n_fail++;
      $display("FAIL sh_done: got rdata=%h err=%b lat=%0d expected 0 0 5", rd, e, lat);
    end
  endtask

  task automatic test_gnt_stall_err();
    int lat, lat0; logic [31:0] rd; logic e, e0;
    do_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 5, 1'b1, lat, rd, e, lat0, e0);
    n_cmp++;
    if (e !== 1'b1 || b_addr.size() != 1 || lat !== 8) begin
      n_fail++;
      $display("FAIL bus_err: got err=%b beats=%0d lat=%0d expected err=1 beats=1 lat=8", e, b_addr.size(), lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, lat0; logic [31:0] rd; logic e, e0; int bad;
    req = 1'b1; we = 1'b0; width = 2'b10; uns = 1'b0; addr = 32'h100;
    @(posedge clk_i);
    @(negedge clk_i); req = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({busy, valid, err, dreq, dwe, dbe, daddr, dwdata, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b valid=%b req=%b rdata=%h expected all 0", busy, valid, dreq, rdata);
    end
    bad = 0;
    repeat (2) begin @(negedge clk_i); if (valid) bad++; end
    rst_ni = 1'b1;
    @(negedge clk_i); spur = 1'b1;
    @(negedge clk_i); spur = 1'b0;
    repeat (2) begin @(negedge clk_i); if (valid || busy) bad++; end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL late_rvalid: got %0d bad cycles expected 0", bad); end
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1'b0, lat, rd, e, lat0, e0);
    n_cmp++;
    if (lat !== 3 || rd !== 32'hABCDEF78 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_lw: got lat=%0d rdata=%h expected lat=3 rdata=abcdef78", lat, rd);
    end
  endtask

  task automatic test_random();
    int lat, lat0, stall, size, nb, j, bad;
    logic [31:0] rd, a, wd, exp, ea, em;
    logic e, e0, iwe, iu, sp, mis;
    logic [1:0] w;
    logic [3:0] xbe [2];
    logic [31:0] xwd [2];
    for (int t = 0; t < 150; t++) begin
      a = $urandom_range(0, 1023); w = 2'($urandom_range(0, 2));
      iwe = 1'($urandom); iu = 1'($urandom); wd = $urandom; stall = $urandom_range(0, 2);
      size = 1 << w;
      sp  = ((a & 3) + size) > 4;
      mis = (a % size) != 0;
      exp = iwe ? 32'h0 : model_load(a, w, iu);
      xbe[0] = '0; xbe[1] = '0; xwd[0] = '0; xwd[1] = '0;
      for (int k = 0; k < size; k++) begin
        j = ((a + k) >> 2) - (a >> 2);
        xbe[j][(a + k) & 3] = 1'b1;
        xwd[j][8*((a + k) & 3) +: 8] = wd[8*k +: 8];
        if (iwe) sh[(a + k) & 32'h3FF] = wd[8*k +: 8];
      end
      do_access(iwe, w, iu, a, wd, stall, 1'b0, lat, rd, e, lat0, e0);
      n_cmp++;
      if (rd !== exp || e !== 1'b0 || lat !== 3 + stall + (sp ? 2 : 0)) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: got rdata=%h err=%b lat=%0d expected rdata=%h err=0 lat=%0d",
                 t, rd, e, lat, exp, 3 + stall + (sp ? 2 : 0));
      end
      nb = sp ? 2 : 1;
      bad = (b_addr.size() != nb) ? 1 : 0;
      if (bad == 0)
        for (int b = 0; b < nb; b++) begin
          ea = (a & ~32'h3) + 32'(4 * b);
          for (int k = 0; k < 4; k++) em[8*k +: 8] = {8{xbe[b][k]}};
          if (b_addr[b] !== ea || b_be[b] !== xbe[b] || b_we[b] !== iwe ||
              (iwe && ((b_wd[b] & em) !== xwd[b]))) bad = 1;
        end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL rand_beats[%0d]: got %0d beats first addr=%h be=%b expected %0d beats addr=%h be=%b",
                 t, b_addr.size(), (b_addr.size() > 0) ? b_addr[0] : 32'hx,
                 (b_be.size() > 0) ? b_be[0] : 4'hx, nb, a & ~32'h3, xbe[0]);
      end
      n_cmp++;
      if (e0 !== mis || lat0 !== (mis ? 1 : 3)) begin
        n_fail++;
        $display("FAIL rand_noalign[%0d]: got err=%b lat=%0d expected err=%b lat=%0d", t, e0, lat0, mis, mis ? 1 : 3);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== {sh[4*i+3], sh[4*i+2], sh[4*i+1], sh[4*i]}) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL mem_final: got %0d differing words expected 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) set_word(4 * i, $urandom);
    set_word(32'h100, 32'hABCDEF78);
    set_word(32'h104, 32'h11223344);
    test_reset();
    test_lw_basic();
    test_load_ext();
    test_misaligned();
    test_store_split();
    test_gnt_stall_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
